// File: rtl/clint_pkg.sv
// Shared CLINT address map and bus width, derived from the global MMIO defines.
// The guarded fallbacks only apply when defines.v has not already been seen.
`ifndef DataBus_WIDTH
`define DataBus_WIDTH 64
`endif
`ifndef MMIO_MTIME
`define MMIO_MTIME 64'h0000_0000_0200_BFF8
`endif
`ifndef MMIO_MTIMECMP
`define MMIO_MTIMECMP 64'h0000_0000_0200_4000
`endif
`ifndef WriteEnable
`define WriteEnable 1'b1
`endif
`ifndef WriteDisable
`define WriteDisable 1'b0
`endif
`ifndef ReadEnable
`define ReadEnable 1'b1
`endif
`ifndef ReadDisable
`define ReadDisable 1'b0
`endif

package clint_pkg;

    localparam int DW = `DataBus_WIDTH;

    localparam logic [DW-1:0] MTIME_ADDR    = `MMIO_MTIME;
    localparam logic [DW-1:0] MTIMECMP_ADDR = `MMIO_MTIMECMP;

    function automatic logic addr_hit(
        input logic            en,
        input logic [DW-1:0]   addr,
        input logic [DW-1:0]   target
    );
        return en && (addr == target);
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides the core clock down to the mtime increment rate.
// clr_i restarts the count so a software mtime write gets a full period.
module clint_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp MMIO registers and the timer IRQ.
// Reads are combinational and return pre-write values on a same-cycle write.
module clint
    import clint_pkg::*;
#(
    parameter int              TICK_DIV     = 1,
    parameter logic [DW-1:0]   MTIMECMP_RST = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clint_wen_i,
    input  logic          clint_ren_i,
    input  logic [DW-1:0] clint_rwaddr_i,
    input  logic [DW-1:0] clint_buswdata_i,
    output logic [DW-1:0] clint_busrdata_o,
    output logic          clint_mtip_o,
    output logic [DW-1:0] clint_mtime_o
);

    logic [DW-1:0] mtime_q;
    logic [DW-1:0] mtime_d;
    logic [DW-1:0] mtimecmp_q;
    logic [DW-1:0] mtimecmp_d;
    logic          mtip_q;
    logic          tick;
    logic          wr_mtime;
    logic          wr_mtimecmp;
    logic          rd_mtime;
    logic          rd_mtimecmp;
    logic          wen;
    logic          ren;

    assign wen = (clint_wen_i == `WriteEnable);
    assign ren = (clint_ren_i == `ReadEnable);

    assign wr_mtime    = addr_hit(wen, clint_rwaddr_i, MTIME_ADDR);
    assign wr_mtimecmp = addr_hit(wen, clint_rwaddr_i, MTIMECMP_ADDR);
    assign rd_mtime    = addr_hit(ren, clint_rwaddr_i, MTIME_ADDR);
    assign rd_mtimecmp = addr_hit(ren, clint_rwaddr_i, MTIMECMP_ADDR);

    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (wr_mtime),
        .tick_o (tick)
    );

    always_comb begin
        mtime_d = mtime_q;
        if (wr_mtime) begin
            mtime_d = clint_buswdata_i;
        end else if (tick) begin
            mtime_d = mtime_q + DW'(1);
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_mtimecmp) begin
            mtimecmp_d = clint_buswdata_i;
        end
    end

    // Compare next-state values so mtip tracks the registers with no lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= (mtime_d >= mtimecmp_d);
        end
    end

    always_comb begin
        clint_busrdata_o = '0;
        if (rd_mtime) begin
            clint_busrdata_o = mtime_q;
        end else if (rd_mtimecmp) begin
            clint_busrdata_o = mtimecmp_q;
        end
    end

    assign clint_mtip_o  = mtip_q;
    assign clint_mtime_o = mtime_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: one TICK_DIV=1 and one TICK_DIV=4 instance
// sharing the same bus stimulus.
module tb_clint;
    import clint_pkg::*;

    logic          clk;
    logic          rst;
    logic          wen;
    logic          ren;
    logic [63:0]   addr;
    logic [63:0]   wdata;
    logic [63:0]   rdata1, rdata4;
    logic [63:0]   mtime1, mtime4;
    logic          mtip1, mtip4;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    clint #(.TICK_DIV(1)) u1 (
        .clk              (clk),
        .rst              (rst),
        .clint_wen_i      (wen),
        .clint_ren_i      (ren),
        .clint_rwaddr_i   (addr),
        .clint_buswdata_i (wdata),
        .clint_busrdata_o (rdata1),
        .clint_mtip_o     (mtip1),
        .clint_mtime_o    (mtime1)
    );

    clint #(.TICK_DIV(4)) u4 (
        .clk              (clk),
        .rst              (rst),
        .clint_wen_i      (wen),
        .clint_ren_i      (ren),
        .clint_rwaddr_i   (addr),
        .clint_buswdata_i (wdata),
        .clint_busrdata_o (rdata4),
        .clint_mtip_o     (mtip4),
        .clint_mtime_o    (mtime4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        wen   = 1'b0;
        ren   = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        wen   = 1'b1;
        ren   = 1'b0;
        addr  = a;
        wdata = d;
        cyc(1);
        idle();
    endtask

    task automatic rd_prep(input logic [63:0] a);
        ren  = 1'b1;
        wen  = 1'b0;
        addr = a;
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc(2);

        chk("rst_mtime1", mtime1, 64'd0);
        chk("rst_mtime4", mtime4, 64'd0);
        chk("rst_mtip1", {63'd0, mtip1}, 64'd0);
        rd_prep(MTIMECMP_ADDR);
        chk("rst_cmp_rd", rdata1, ALL1);
        idle();

        rst = 1'b0;
        cyc(10);
        chk("idle10_mtime", mtime1, 64'd10);
        chk("idle10_mtip", {63'd0, mtip1}, 64'd0);
        chk("ren0_rdata", rdata1, 64'd0);
        rd_prep(MTIMECMP_ADDR);
        chk("idle10_cmp", rdata1, ALL1);
        idle();

        cyc(2);
        chk("div4_12cyc", mtime4, 64'd3);
        cyc(3);
        chk("div4_15cyc", mtime4, 64'd3);
        wr(MTIME_ADDR, 64'd100);
        chk("div4_wr100", mtime4, 64'd100);
        cyc(3);
        chk("div4_hold3", mtime4, 64'd100);
        cyc(1);
        chk("div4_next", mtime4, 64'd101);

        wr(MTIMECMP_ADDR, 64'd20);
        chk("cmp20_mtip_hi", {63'd0, mtip1}, 64'd1);
        wr(MTIME_ADDR, 64'd15);
        chk("mt15_val", mtime1, 64'd15);
        chk("mt15_mtip", {63'd0, mtip1}, 64'd0);
        cyc(4);
        chk("mt19_mtip", {63'd0, mtip1}, 64'd0);
        cyc(1);
        chk("mt20_val", mtime1, 64'd20);
        chk("mt20_mtip", {63'd0, mtip1}, 64'd1);
        wr(MTIMECMP_ADDR, 64'd1000);
        chk("cmp1000_mtip", {63'd0, mtip1}, 64'd0);

        wr(MTIMECMP_ADDR, 64'd5);
        wr(MTIME_ADDR, 64'hFFFF_FFFF_FFFF_FFFE);
        rd_prep(MTIME_ADDR);
        chk("wrap_fffe", rdata1, 64'hFFFF_FFFF_FFFF_FFFE);
        cyc(1);
        chk("wrap_ffff", rdata1, ALL1);
        chk("wrap_mtip_hi", {63'd0, mtip1}, 64'd1);
        cyc(1);
        chk("wrap_zero", rdata1, 64'd0);
        chk("wrap_mtip_lo", {63'd0, mtip1}, 64'd0);
        idle();

        wr(MTIMECMP_ADDR, 64'd7);
        wen   = 1'b1;
        ren   = 1'b1;
        addr  = MTIMECMP_ADDR;
        wdata = 64'd9;
        #1;
        chk("rw_old", rdata1, 64'd7);
        cyc(1);
        wen = 1'b0;
        #1;
        chk("rw_new", rdata1, 64'd9);

        wen   = 1'b1;
        addr  = 64'h0000_0000_8000_0000;
        wdata = 64'd123;
        #1;
        chk("bad_rdata", rdata1, 64'd0);
        cyc(1);
        idle();
        rd_prep(MTIMECMP_ADDR);
        chk("bad_cmp", rdata1, 64'd9);
        chk("bad_mtime", mtime1, 64'd3);
        chk("bad_mtip", {63'd0, mtip1}, 64'd0);
        idle();

        wr(MTIMECMP_ADDR, 64'd2);
        chk("pre_rst_mtip", {63'd0, mtip1}, 64'd1);
        rst   = 1'b1;
        wen   = 1'b1;
        addr  = MTIME_ADDR;
        wdata = 64'd55;
        cyc(1);
        idle();
        chk("mid_rst_mtime", mtime1, 64'd0);
        chk("mid_rst_mtime4", mtime4, 64'd0);
        chk("mid_rst_mtip", {63'd0, mtip1}, 64'd0);
        rd_prep(MTIMECMP_ADDR);
        chk("mid_rst_cmp", rdata1, ALL1);
        idle();
        rst = 1'b0;
        cyc(1);
        chk("post_rst_mtime", mtime1, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clint.md
Name: clint

Overview:
Core-local interruptor for the single-cycle NPC. Sits directly downstream of the memory crossbar on the MMIO path and owns the `MMIO_MTIME` and `MMIO_MTIMECMP` registers. Drives `clint_busrdata_o` back to the crossbar within the same cycle. Raises the machine timer-interrupt pending line towards the CSR/trap unit.

Parameters:
- TICK_DIV, 1, core-clock cycles per mtime increment; legal range is ≥1.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp. This keeps the interrupt inactive after reset.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous, active-high reset
- clint_wen_i  input  1  write enable, already address-qualified by the crossbar
- clint_ren_i  input  1  read enable, already address-qualified by the crossbar
- clint_rwaddr_i  input  `DataBus_WIDTH  byte address of the access
- clint_buswdata_i  input  `DataBus_WIDTH  write data; always a full 64-bit write
- clint_busrdata_o  output  `DataBus_WIDTH  read data, combinational
- clint_mtip_o  output  1  machine timer interrupt pending, registered
- clint_mtime_o  output  `DataBus_WIDTH  current mtime, for difftest and debug

Behaviour:
- Reset (rst=1 at a clk edge):
  - mtime=0, mtimecmp=MTIMECMP_RST, prescaler=0, clint_mtip_o=0.
  - Reset overrides any same-cycle write or tick.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick = (prescaler==TICK_DIV-1). On tick the prescaler wraps to 0.
  - With TICK_DIV=1, tick is asserted every cycle.
- mtime update priority, highest first:
  1. wen && addr==`MMIO_MTIME: mtime <= wdata, and prescaler <= 0.
  2. tick: mtime <= mtime+1, modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  3. Otherwise hold.
- mtimecmp: wen && addr==`MMIO_MTIMECMP gives mtimecmp <= wdata; otherwise hold.
- Address matching:
  - Exact 64-bit compare against each define.
  - wen/ren with any other address: no state change, rdata=0.
  - This case is normally filtered out upstream by the crossbar.
- Read path:
  - Purely combinational.
  - ren && addr==`MMIO_MTIME gives the current mtime register; ren && addr==`MMIO_MTIMECMP gives mtimecmp; else 0.
  - ren=0 gives rdata=0.
- Simultaneous ren and wen to the same address: rdata returns the pre-write value. The new value is visible from the next cycle.
- clint_mtip_o:
  - Register loaded each edge with the unsigned compare (mtime_next >= mtimecmp_next).
  - The invariant clint_mtip_o == (mtime >= mtimecmp) therefore holds every cycle after reset, with no extra lag.
- Interrupt clearing: writing mtimecmp above mtime deasserts mtip in the same edge that updates mtimecmp.
- No handshake or stall: every access completes in one cycle, consistent with the single-cycle LSU.

Decomposition:
- Shared header defines.v carries `DataBus_WIDTH`, `MMIO_MTIME`, `MMIO_MTIMECMP`, `WriteEnable`/`WriteDisable` and `ReadEnable`/`ReadDisable`. None are redefined locally.
- One natural sub-module: clint_prescaler.
  - Parameter TICK_DIV.
  - Ports: clk, rst, clr_i, tick_o.
  - Counter width is $clog2(TICK_DIV) with a minimum of 1.
- mtime, mtimecmp and mtip remain in clint.

Test Plan:
- Reset release, TICK_DIV=1, idle for 10 cycles -> mtime=10, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtip=0, rdata=0 while ren=0.
- TICK_DIV=4, idle for 12 cycles after reset -> mtime=3. A write of mtime=100 in the cycle where tick would fire -> mtime=100, with the next increment 4 cycles later (101).
- Write mtimecmp=20 with mtime=15 and TICK_DIV=1 -> mtip rises on the edge where mtime becomes 20. A later write of mtimecmp=1000 -> mtip=0 after that edge.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFE, TICK_DIV=1 -> reads return ...FFFF and then 0 on successive cycles. With mtimecmp=5, mtip drops to 0 at the wrap.
- Same-cycle ren+wen on `MMIO_MTIMECMP` (old 7, new 9) -> rdata=7 that cycle, 9 the next. wen to address 0x8000_0000 -> no register change.
- Assert rst mid-count with mtip=1 -> next cycle mtime=0, mtimecmp=MTIMECMP_RST, mtip=0, and a simultaneous mtime write is ignored.
